// File: rtl/cnt_sched_if.sv
// cnt_sched_if: bundle of requester-facing signals for the shared counter
// scheduler.
//
// Handshake: a requester raises req_x together with dir_x/len_x and holds
// req_x until it sees done_x; dir_x/len_x are sampled only on the cycle the
// grant is taken. gnt_x stays high for the whole run including the done
// cycle. Dropping req_x while granted (before done_x) aborts the run.
// done_x is a single-cycle pulse and is only ever high together with gnt_x.
//
// Signals:
//   req_a/req_b   requester wants the counter
//   dir_a/dir_b   0 = increment, 1 = decrement
//   len_a/len_b   number of single steps to take
//   clr           clear Q, honoured only while idle with no winner
//   gnt_a/gnt_b   ownership of the counter
//   done_a/done_b run-complete pulse
//   busy          scheduler is not idle
//   Q             counter value
//   state_dbg     scheduler FSM state (debug observation)
interface cnt_sched_if #(
    parameter int WIDTH = 4,
    parameter int LENW  = 4
);
    logic             req_a;
    logic             dir_a;
    logic [LENW-1:0]  len_a;
    logic             req_b;
    logic             dir_b;
    logic [LENW-1:0]  len_b;
    logic             clr;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic             busy;
    logic [WIDTH-1:0] Q;
    logic [1:0]       state_dbg;

    modport master (
        output req_a, dir_a, len_a, req_b, dir_b, len_b, clr,
        input  gnt_a, gnt_b, done_a, done_b, busy, Q, state_dbg
    );

    modport slave (
        input  req_a, dir_a, len_a, req_b, dir_b, len_b, clr,
        output gnt_a, gnt_b, done_a, done_b, busy, Q, state_dbg
    );
endinterface

// File: rtl/cnt_sched.sv
// cnt_sched: shares one up/down counter between requesters A and B.
// Round-robin arbitration grants the counter to one owner, which steps it
// once per cycle for len cycles, then receives a one-cycle done pulse.
//
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous, active-high reset
//   bus  cnt_sched_if slave modport (requests, grants, done, busy, Q,
//        state_dbg)
//
// All outputs are registered.
module cnt_sched #(
    parameter int WIDTH = 4,
    parameter int LENW  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    cnt_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic             owner;      // 0 = A, 1 = B
    logic             dir;        // 0 = up, 1 = down
    logic             ptr;        // side that wins a tie (0 = A)
    logic [LENW-1:0]  remaining;
    logic [WIDTH-1:0] q;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic             busy;

    logic             win_a;
    logic             win_b;
    logic             owner_req;

    // A lone requester always wins; on a tie the ptr side wins, so win_a and
    // win_b are mutually exclusive.
    always_comb begin
        win_a     = bus.req_a && (!bus.req_b || !ptr);
        win_b     = bus.req_b && (!bus.req_a ||  ptr);
        owner_req = owner ? bus.req_b : bus.req_a;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            dir       <= 1'b0;
            ptr       <= 1'b0;
            remaining <= '0;
            q         <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    if (win_a || win_b) begin
                        // A win takes precedence over clr in the same cycle.
                        owner     <= win_b;
                        dir       <= win_b ? bus.dir_b : bus.dir_a;
                        remaining <= win_b ? bus.len_b : bus.len_a;
                        gnt_a     <= win_a;
                        gnt_b     <= win_b;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end else if (bus.clr) begin
                        q <= '0;
                    end
                end
                S_RUN: begin
                    if (!owner_req) begin
                        // Abort: no step this cycle, no done pulse.
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        busy  <= 1'b0;
                        ptr   <= ~owner;
                        state <= S_IDLE;
                    end else if (remaining != '0) begin
                        q         <= dir ? q - WIDTH'(1) : q + WIDTH'(1);
                        remaining <= remaining - LENW'(1);
                    end else begin
                        done_a <= ~owner;
                        done_b <= owner;
                        ptr    <= ~owner;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt_a  <= 1'b0;
                    gnt_b  <= 1'b0;
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    gnt_a  <= 1'b0;
                    gnt_b  <= 1'b0;
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.done_a    = done_a;
    assign bus.done_b    = done_b;
    assign bus.busy      = busy;
    assign bus.Q         = q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: directed self-checking bench for cnt_sched.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. after the edge has taken effect.
module tb_cnt_sched;

    logic CLK = 1'b0;
    logic RST;
    int   nchecks = 0;
    int   nerrors = 0;

    cnt_sched_if #(.WIDTH(4), .LENW(4)) bus();

    cnt_sched #(.WIDTH(4), .LENW(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req_a = 1'b0; bus.dir_a = 1'b0; bus.len_a = 4'd0;
        bus.req_b = 1'b0; bus.dir_b = 1'b0; bus.len_b = 4'd0;
        bus.clr   = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle_inputs();
        repeat (2) tick();
        nchecks++; if (bus.Q !== 4'd0) begin nerrors++; $display("FAIL reset_q: got %0d expected 0", bus.Q); end
        nchecks++; if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin nerrors++; $display("FAIL reset_gnt: got %b%b expected 00", bus.gnt_a, bus.gnt_b); end
        nchecks++; if (bus.done_a !== 1'b0 || bus.done_b !== 1'b0) begin nerrors++; $display("FAIL reset_done: got %b%b expected 00", bus.done_a, bus.done_b); end
        nchecks++; if (bus.busy !== 1'b0) begin nerrors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        nchecks++; if (bus.state_dbg !== 2'd0) begin nerrors++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
        RST = 1'b0;
        tick();
    endtask

    // A up by 5 from 0: gnt_a for 7 cycles, Q = 1..5, done_a once.
    task automatic test_run_a;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd5;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1 || bus.busy !== 1'b1 || bus.gnt_b !== 1'b0) begin nerrors++; $display("FAIL run_a_grant: got gnt_a=%b gnt_b=%b busy=%b expected 1 0 1", bus.gnt_a, bus.gnt_b, bus.busy); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            nchecks++; if (bus.Q !== 4'(i) || bus.gnt_a !== 1'b1 || bus.done_a !== 1'b0) begin nerrors++; $display("FAIL run_a_step%0d: got q=%0d gnt_a=%b done_a=%b expected %0d 1 0", i, bus.Q, bus.gnt_a, bus.done_a, i); end
        end
        tick();
        nchecks++; if (bus.done_a !== 1'b1 || bus.gnt_a !== 1'b1 || bus.Q !== 4'd5) begin nerrors++; $display("FAIL run_a_done: got done_a=%b gnt_a=%b q=%0d expected 1 1 5", bus.done_a, bus.gnt_a, bus.Q); end
        bus.req_a = 1'b0;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b0 || bus.busy !== 1'b0 || bus.done_a !== 1'b0 || bus.Q !== 4'd5) begin nerrors++; $display("FAIL run_a_end: got gnt_a=%b busy=%b done_a=%b q=%0d expected 0 0 0 5", bus.gnt_a, bus.busy, bus.done_a, bus.Q); end
    endtask

    // B down 3 from 0 wraps to 15,14,13; then A up 4 from 13 wraps to 0,1.
    task automatic test_wrap;
        logic [3:0] exp_b [3];
        logic [3:0] exp_a [4];
        exp_b = '{4'd15, 4'd14, 4'd13};
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        bus.clr = 1'b1;
        tick();
        nchecks++; if (bus.Q !== 4'd0) begin nerrors++; $display("FAIL wrap_clr: got %0d expected 0", bus.Q); end
        bus.clr = 1'b0;
        bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.len_b = 4'd3;
        tick();
        nchecks++; if (bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0) begin nerrors++; $display("FAIL wrap_gnt_b: got gnt_a=%b gnt_b=%b expected 0 1", bus.gnt_a, bus.gnt_b); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nchecks++; if (bus.Q !== exp_b[i]) begin nerrors++; $display("FAIL wrap_down%0d: got %0d expected %0d", i, bus.Q, exp_b[i]); end
        end
        tick();
        nchecks++; if (bus.done_b !== 1'b1 || bus.gnt_b !== 1'b1) begin nerrors++; $display("FAIL wrap_done_b: got done_b=%b gnt_b=%b expected 1 1", bus.done_b, bus.gnt_b); end
        bus.req_b = 1'b0;
        tick();
        nchecks++; if (bus.busy !== 1'b0) begin nerrors++; $display("FAIL wrap_idle_b: got busy=%b expected 0", bus.busy); end
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd4;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1) begin nerrors++; $display("FAIL wrap_gnt_a: got %b expected 1", bus.gnt_a); end
        for (int i = 0; i < 4; i++) begin
            tick();
            nchecks++; if (bus.Q !== exp_a[i]) begin nerrors++; $display("FAIL wrap_up%0d: got %0d expected %0d", i, bus.Q, exp_a[i]); end
        end
        tick();
        nchecks++; if (bus.done_a !== 1'b1) begin nerrors++; $display("FAIL wrap_done_a: got %b expected 1", bus.done_a); end
        bus.req_a = 1'b0;
        tick();
        nchecks++; if (bus.busy !== 1'b0 || bus.Q !== 4'd1) begin nerrors++; $display("FAIL wrap_end: got busy=%b q=%0d expected 0 1", bus.busy, bus.Q); end
    endtask

    // Both held: after a reset ptr favours A, so order is A, B, A, B.
    task automatic test_contention;
        logic       exp_b_owner;
        logic [3:0] exp_q;
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        tick();
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd2;
        bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.len_b = 4'd2;
        for (int r = 0; r < 4; r++) begin
            exp_b_owner = (r % 2 == 1);
            exp_q       = exp_b_owner ? 4'd0 : 4'd2;
            tick();
            nchecks++; if (bus.gnt_a !== ~exp_b_owner || bus.gnt_b !== exp_b_owner) begin nerrors++; $display("FAIL cont_gnt%0d: got gnt_a=%b gnt_b=%b expected %b %b", r, bus.gnt_a, bus.gnt_b, ~exp_b_owner, exp_b_owner); end
            repeat (2) begin
                tick();
                nchecks++; if (bus.gnt_a === 1'b1 && bus.gnt_b === 1'b1) begin nerrors++; $display("FAIL cont_overlap%0d: got gnt_a=1 gnt_b=1 expected not both", r); end
            end
            tick();
            nchecks++; if ((exp_b_owner ? bus.done_b : bus.done_a) !== 1'b1 || bus.Q !== exp_q) begin nerrors++; $display("FAIL cont_done%0d: got done_a=%b done_b=%b q=%0d expected q=%0d", r, bus.done_a, bus.done_b, bus.Q, exp_q); end
            if (r == 3) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            tick();
            nchecks++; if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin nerrors++; $display("FAIL cont_release%0d: got gnt_a=%b gnt_b=%b expected 0 0", r, bus.gnt_a, bus.gnt_b); end
        end
    endtask

    // A aborts at Q=3; B (pending) is granted the next cycle.
    task automatic test_abort;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd10;
        bus.req_b = 1'b1; bus.dir_b = 1'b0; bus.len_b = 4'd1;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin nerrors++; $display("FAIL abort_gnt_a: got gnt_a=%b gnt_b=%b expected 1 0", bus.gnt_a, bus.gnt_b); end
        for (int i = 1; i <= 3; i++) tick();
        nchecks++; if (bus.Q !== 4'd3) begin nerrors++; $display("FAIL abort_pre_q: got %0d expected 3", bus.Q); end
        bus.req_a = 1'b0;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b0 || bus.busy !== 1'b0 || bus.done_a !== 1'b0 || bus.Q !== 4'd3) begin nerrors++; $display("FAIL abort_stop: got gnt_a=%b busy=%b done_a=%b q=%0d expected 0 0 0 3", bus.gnt_a, bus.busy, bus.done_a, bus.Q); end
        tick();
        nchecks++; if (bus.gnt_b !== 1'b1 || bus.Q !== 4'd3) begin nerrors++; $display("FAIL abort_gnt_b: got gnt_b=%b q=%0d expected 1 3", bus.gnt_b, bus.Q); end
        tick();
        nchecks++; if (bus.Q !== 4'd4) begin nerrors++; $display("FAIL abort_b_step: got %0d expected 4", bus.Q); end
        tick();
        nchecks++; if (bus.done_b !== 1'b1) begin nerrors++; $display("FAIL abort_done_b: got %b expected 1", bus.done_b); end
        bus.req_b = 1'b0;
        tick();
        nchecks++; if (bus.busy !== 1'b0 || bus.Q !== 4'd4) begin nerrors++; $display("FAIL abort_end: got busy=%b q=%0d expected 0 4", bus.busy, bus.Q); end
    endtask

    // len=0 at Q=7, clr ignored while busy and on a win, clr honoured idle.
    task automatic test_len0_clr;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd3;
        repeat (5) tick();
        bus.req_a = 1'b0;
        tick();
        nchecks++; if (bus.Q !== 4'd7 || bus.busy !== 1'b0) begin nerrors++; $display("FAIL len0_setup: got q=%0d busy=%b expected 7 0", bus.Q, bus.busy); end
        bus.req_a = 1'b1; bus.len_a = 4'd0;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1 || bus.done_a !== 1'b0 || bus.Q !== 4'd7) begin nerrors++; $display("FAIL len0_gnt: got gnt_a=%b done_a=%b q=%0d expected 1 0 7", bus.gnt_a, bus.done_a, bus.Q); end
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1 || bus.done_a !== 1'b1 || bus.Q !== 4'd7) begin nerrors++; $display("FAIL len0_done: got gnt_a=%b done_a=%b q=%0d expected 1 1 7", bus.gnt_a, bus.done_a, bus.Q); end
        bus.req_a = 1'b0;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b0 || bus.Q !== 4'd7) begin nerrors++; $display("FAIL len0_end: got gnt_a=%b q=%0d expected 0 7", bus.gnt_a, bus.Q); end
        bus.req_b = 1'b1; bus.dir_b = 1'b0; bus.len_b = 4'd2; bus.clr = 1'b1;
        tick();
        nchecks++; if (bus.gnt_b !== 1'b1 || bus.Q !== 4'd7) begin nerrors++; $display("FAIL clr_win: got gnt_b=%b q=%0d expected 1 7", bus.gnt_b, bus.Q); end
        tick();
        nchecks++; if (bus.Q !== 4'd8) begin nerrors++; $display("FAIL clr_busy1: got %0d expected 8", bus.Q); end
        tick();
        nchecks++; if (bus.Q !== 4'd9) begin nerrors++; $display("FAIL clr_busy2: got %0d expected 9", bus.Q); end
        tick();
        nchecks++; if (bus.done_b !== 1'b1 || bus.Q !== 4'd9) begin nerrors++; $display("FAIL clr_done_b: got done_b=%b q=%0d expected 1 9", bus.done_b, bus.Q); end
        bus.req_b = 1'b0; bus.clr = 1'b0;
        tick();
        nchecks++; if (bus.busy !== 1'b0 || bus.Q !== 4'd9) begin nerrors++; $display("FAIL clr_end_b: got busy=%b q=%0d expected 0 9", bus.busy, bus.Q); end
        bus.clr = 1'b1;
        tick();
        nchecks++; if (bus.Q !== 4'd0 || bus.busy !== 1'b0) begin nerrors++; $display("FAIL clr_idle: got q=%0d busy=%b expected 0 0", bus.Q, bus.busy); end
        bus.clr = 1'b0;
    endtask

    // A len=0 leaves ptr at B; RST mid-run must clear Q/gnt/busy and ptr.
    task automatic test_async_reset;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.len_a = 4'd0;
        repeat (2) tick();
        bus.req_a = 1'b0;
        tick();
        bus.req_a = 1'b1; bus.len_a = 4'd9;
        tick();
        repeat (6) tick();
        nchecks++; if (bus.Q !== 4'd6 || bus.gnt_a !== 1'b1) begin nerrors++; $display("FAIL arst_pre: got q=%0d gnt_a=%b expected 6 1", bus.Q, bus.gnt_a); end
        #3 RST = 1'b1;
        #1;
        nchecks++; if (bus.Q !== 4'd0 || bus.gnt_a !== 1'b0 || bus.busy !== 1'b0 || bus.done_a !== 1'b0) begin nerrors++; $display("FAIL arst_now: got q=%0d gnt_a=%b busy=%b done_a=%b expected 0 0 0 0", bus.Q, bus.gnt_a, bus.busy, bus.done_a); end
        bus.req_a = 1'b0;
        #1 RST = 1'b0;
        repeat (2) begin
            tick();
            nchecks++; if (bus.done_a !== 1'b0 || bus.busy !== 1'b0) begin nerrors++; $display("FAIL arst_quiet: got done_a=%b busy=%b expected 0 0", bus.done_a, bus.busy); end
        end
        bus.req_a = 1'b1; bus.len_a = 4'd0;
        bus.req_b = 1'b1; bus.len_b = 4'd0;
        tick();
        nchecks++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin nerrors++; $display("FAIL arst_ptr: got gnt_a=%b gnt_b=%b expected 1 0", bus.gnt_a, bus.gnt_b); end
        tick();
        nchecks++; if (bus.done_a !== 1'b1 || bus.done_b !== 1'b0) begin nerrors++; $display("FAIL arst_done: got done_a=%b done_b=%b expected 1 0", bus.done_a, bus.done_b); end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        tick();
        nchecks++; if (bus.busy !== 1'b0) begin nerrors++; $display("FAIL arst_end: got busy=%b expected 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_run_a();
        test_wrap();
        test_contention();
        test_abort();
        test_len0_clr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
# cnt_sched

Scheduler that shares one up/down counter between two requesters, A and B. Each requester asks for a run of N single steps in a chosen direction. The block arbitrates round-robin, grants the counter to one owner, steps it once per cycle for N cycles, then signals completion. It sits in front of the counter datapath and replaces fixed, elaboration-time up/down selection with run-time sequencing.

## Interface
- WIDTH, 4, counter width; Q wraps modulo 2^WIDTH.
- LENW, 4, width of the run-length fields.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_a  in  1  requester A wants the counter; held until done_a or abort.
- dir_a  in  1  A's direction, 0 = increment, 1 = decrement; sampled at grant.
- len_a  in  LENW  A's number of steps; sampled at grant.
- req_b, dir_b, len_b: same as above, for requester B.
- clr  in  1  synchronous clear of Q; honoured only in IDLE.
- gnt_a  out  1  A owns the counter (RUN and DONE).
- gnt_b  out  1  B owns the counter.
- done_a  out  1  one-cycle pulse, A's run completed.
- done_b  out  1  one-cycle pulse, B's run completed.
- busy  out  1  state is not IDLE.
- Q  out  WIDTH  counter value.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: owner, dir, remaining[LENW], priority pointer ptr (0 = A first).
- IDLE, no request: if clr=1, Q <= 0; stay in IDLE.
- IDLE, exactly one request: that requester wins.
- IDLE, both requesting: the ptr side wins.
- On a win: latch owner, dir and len into remaining; assert the owner's gnt; go to RUN.
- clr in the same cycle as a win is ignored.
- RUN, remaining != 0: Q <= Q ± 1 modulo 2^WIDTH, remaining <= remaining − 1.
- RUN, remaining == 0: go to DONE. len = 0 therefore gives grant, then DONE, with Q unchanged.
- RUN, owner's req drops (abort): go to IDLE next edge with no step that cycle. No done pulse. Q holds its current value.
- DONE: owner's done pulses for this one cycle with gnt still high; go to IDLE.
- ptr update: set ptr to the non-owner on entry to DONE or on abort. This gives strict alternation under contention.
- Non-owner requests and clr are ignored while busy; pending requests stay pending.
- A req still high in IDLE after done is treated as a new request.
- gnt_a and gnt_b are never both 1. done_x is never high without gnt_x.
- Wrap: 0 − 1 = 2^WIDTH − 1; 2^WIDTH − 1 + 1 = 0. No saturation, no flags.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, Q = 0, gnt_a = gnt_b = 0, done_a = done_b = 0, busy = 0, ptr = A, remaining = 0.
  - RST mid-run aborts the run; Q returns to 0 and no done pulse is issued.
- All outputs are registered.
- req seen high at edge t in IDLE: gnt and busy are high from edge t.
- Q steps at edges t+1 … t+len. The new value of Q is visible after each of those edges.
- State is DONE after edge t+len+1; done is high for the following cycle; IDLE after edge t+len+2.
- Throughput: a run of len steps occupies len + 3 cycles from request to the next possible grant.
- Abort: req sampled low at edge e in RUN: gnt and busy fall after edge e. The last step of Q is at edge e−1.
- clr sampled at edge t in IDLE with no request: Q = 0 after edge t.

## Test plan
- Reset, then A: dir=0, len=5 from Q=0. Expect gnt_a for 7 cycles; Q = 1,2,3,4,5 on consecutive edges; done_a one cycle; final Q=5; busy then low.
- Wrap-around: Q=0, B with dir=1, len=3. Expect Q = 15,14,13 and done_b. Then A with dir=0, len=4 from 13: expect Q = 14,15,0,1.
- Simultaneous requests held continuously: A len=2 up, B len=2 down from Q=0. Expect order A, B, A, B; Q = 2,0,2,0 at the end of each run; gnt_a and gnt_b never overlap.
- Abort: A len=10 up from 0; drop req_a after Q reaches 3. Expect Q holds 3, no done_a, busy low next cycle, and B (pending) granted next.
- len=0 and clr: A len=0 with Q=7. Expect gnt_a, then done_a, with Q=7 throughout. clr pulse in IDLE gives Q=0; clr pulse during a B run is ignored.
- Asynchronous RST asserted mid-run (Q=6, remaining=3). Expect immediate Q=0, gnt=0, busy=0, no done pulse, and ptr=A afterwards.
